// File: rtl/down_counter_if.sv
// down_counter_if: control/status bundle between a down_counter and its user
//   master: drives clr, load_valid, load_value, en, auto_reload; observes load_ready, count, tc, busy
//   slave : the counter side of the same signals
interface down_counter_if #(parameter int WIDTH = 4);
  logic             clr;
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  modport master (
    output clr, load_valid, load_value, en, auto_reload,
    input  load_ready, count, tc, busy
  );
  modport slave (
    input  clr, load_valid, load_value, en, auto_reload,
    output load_ready, count, tc, busy
  );
endinterface

// File: rtl/down_counter.sv
// down_counter: loadable down counter with terminal-count pulse and optional auto-reload
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : down_counter_if.slave -- clr, load handshake (load_valid/load_value/load_ready),
//         en, auto_reload in; count, tc, busy out
module down_counter #(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         rst,
  down_counter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             run;
  assign run            = state == RUN;
  assign bus.busy       = run;
  assign bus.load_ready = !run;
  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.clr) begin
        state   <= IDLE;
        count_q <= '0;
      end else if (!run) begin
        if (bus.load_valid) begin
          count_q  <= bus.load_value;
          reload_q <= bus.load_value;
          state    <= RUN;
        end
      end else if (bus.en) begin
        // terminal edge replaces the decrement, so count never wraps below zero
        if (count_q == '0) begin
          tc_q <= 1'b1;
          if (bus.auto_reload) count_q <= reload_q;
          else state <= DONE;
        end else begin
          count_q <= count_q - 1'b1;
        end
      end
    end
  end
endmodule
